ctrl_pipe_chain: RTL and testbench

Parametrised control-pipeline register chain; successor to the fixed-field D->E control register.
- Carries an opaque packed control word of WIDTH bits through DEPTH register stages, with a valid bit per stage.
- Supports stall, flush with two flush modes, and bubble zeroing.
- Provides an occupancy output and a saturating bubble performance counter.
- Instantiated between any two pipeline stages, e.g. Decode->Execute. Also used for deeper multi-cycle paths such as Execute->Writeback in the multiply unit.

---
 rtl/ctrl_pipe_pkg.sv | 7 +
 rtl/ctrl_pipe_stage.sv | 29 ++
 rtl/ctrl_pipe_chain.sv | 70 +++++++
 tb/tb_ctrl_pipe_chain.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types and sizing helpers for the control pipeline chain
package ctrl_pipe_pkg;
  typedef enum int {FLUSH_ALL = 0, FLUSH_KEEP_OLDEST = 1} flush_mode_e;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one valid+data register with reset/clear/hold priority and bubble zeroing
module ctrl_pipe_stage #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  // bubbles always carry RST_VAL so downstream write-enable fields read as 0
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else if (!hold) begin
      r_valid <= d_valid;
      r_data  <= d_valid ? d_data : RST_VAL;
    end
  end
  assign q_valid = r_valid;
  assign q_data  = r_data;
endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: parametrised control-word pipeline with stall, flush, occupancy and bubble counter
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1,
  parameter int FLUSH_MODE = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy,
  output logic [CNT_W-1:0]          bubble_cnt,
  input  logic                      clr_cnt
);
  localparam int OCC_W = occ_w(DEPTH);
  localparam bit KEEP_OLDEST = (FLUSH_MODE == int'(FLUSH_KEEP_OLDEST)) && (DEPTH > 1);
  logic [DEPTH-1:0] w_valid, w_dv, w_clr, w_nv;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [WIDTH-1:0] w_dd [DEPTH];
  logic [OCC_W-1:0] w_pop, r_occ;
  logic [CNT_W-1:0] r_cnt;
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_dv[s] = in_valid;
      assign w_dd[s] = in_data;
    end else begin : g_body
      assign w_dv[s] = w_valid[s-1];
      assign w_dd[s] = w_data[s-1];
    end
    assign w_clr[s] = flush && !(KEEP_OLDEST && s == DEPTH - 1 && stall);
    assign w_nv[s]  = w_clr[s] ? 1'b0 : stall ? w_valid[s] : w_dv[s];
    ctrl_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clr[s]),
      .hold    (stall),
      .d_valid (w_dv[s]),
      .d_data  (w_dd[s]),
      .q_valid (w_valid[s]),
      .q_data  (w_data[s])
    );
  end
  // popcount of the valid bits each stage is about to load
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) w_pop = w_pop + OCC_W'(w_nv[i]);
  end
  // occupancy tracks valid[] on the same edge
  always_ff @(posedge clk) begin
    if (reset) r_occ <= '0;
    else r_occ <= w_pop;
  end
  // saturating count of cycles where the oldest stage emits a bubble while advancing
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) r_cnt <= '0;
    else if (!flush && !stall && !w_valid[DEPTH-1] && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign out_valid  = w_valid[DEPTH-1];
  assign out_data   = w_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign bubble_cnt = r_cnt;
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: three configurations driven in lockstep and checked against a behavioural model
module tb_ctrl_pipe_chain;
  logic clk = 0;
  logic reset = 0, stall = 0, flush = 0, in_valid = 0, clr_cnt = 0;
  logic [15:0] in_data = '0;
  logic ov_a, ov_b, ov_c;
  logic [15:0] od_a, od_b, od_c;
  logic [0:0] oc_a;
  logic [1:0] oc_b, oc_c;
  logic [15:0] bc_a, bc_b;
  logic [2:0] bc_c;
  int n_chk = 0, n_err = 0;
  int dep [3] = '{1, 3, 3};
  int mode [3] = '{0, 0, 1};
  int cmax [3] = '{65535, 65535, 7};
  logic [15:0] rv [3] = '{16'h0000, 16'h0000, 16'hBEEF};
  bit mv [3][3];
  logic [15:0] md [3][3];
  int mcnt [3];
  always #5 clk = ~clk;
  ctrl_pipe_chain #(.WIDTH(16), .DEPTH(1), .FLUSH_MODE(0), .RST_VAL(16'h0000), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_a), .out_data(od_a), .occupancy(oc_a), .bubble_cnt(bc_a), .clr_cnt(clr_cnt));
  ctrl_pipe_chain #(.WIDTH(16), .DEPTH(3), .FLUSH_MODE(0), .RST_VAL(16'h0000), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_b), .out_data(od_b), .occupancy(oc_b), .bubble_cnt(bc_b), .clr_cnt(clr_cnt));
  ctrl_pipe_chain #(.WIDTH(16), .DEPTH(3), .FLUSH_MODE(1), .RST_VAL(16'hBEEF), .CNT_W(3)) u_c (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_c), .out_data(od_c), .occupancy(oc_c), .bubble_cnt(bc_c), .clr_cnt(clr_cnt));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int d = dep[k];
      if (reset) begin
        for (int s = 0; s < 3; s++) begin
          mv[k][s] = 0;
          md[k][s] = rv[k];
        end
        mcnt[k] = 0;
      end else begin
        if (clr_cnt) mcnt[k] = 0;
        else if (!flush && !stall && !mv[k][d-1] && mcnt[k] < cmax[k]) mcnt[k]++;
        if (flush) begin
          for (int s = 0; s < d; s++)
            if (!(mode[k] == 1 && d > 1 && s == d - 1 && stall)) begin
              mv[k][s] = 0;
              md[k][s] = rv[k];
            end
        end else if (!stall) begin
          for (int s = d - 1; s > 0; s--) begin
            mv[k][s] = mv[k][s-1];
            md[k][s] = md[k][s-1];
          end
          mv[k][0] = in_valid;
          md[k][0] = in_valid ? in_data : rv[k];
        end
      end
    end
  endtask
  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      logic g_v;
      logic [15:0] g_d, g_o, g_b;
      int occ = 0;
      int d = dep[k];
      for (int s = 0; s < d; s++) occ += int'(mv[k][s]);
      case (k)
        0: begin g_v = ov_a; g_d = od_a; g_o = 16'(oc_a); g_b = bc_a; end
        1: begin g_v = ov_b; g_d = od_b; g_o = 16'(oc_b); g_b = bc_b; end
        default: begin g_v = ov_c; g_d = od_c; g_o = 16'(oc_c); g_b = 16'(bc_c); end
      endcase
      check($sformatf("cfg%0d out_valid", k), 32'(g_v), 32'(mv[k][d-1]));
      check($sformatf("cfg%0d out_data", k), 32'(g_d), 32'(md[k][d-1]));
      check($sformatf("cfg%0d occupancy", k), 32'(g_o), 32'(occ));
      check($sformatf("cfg%0d bubble_cnt", k), 32'(g_b), 32'(mcnt[k]));
    end
  endtask
  task automatic cyc(input bit r, input bit st, input bit fl, input bit iv, input logic [15:0] id, input bit cc);
    reset = r;
    stall = st;
    flush = fl;
    in_valid = iv;
    in_data = id;
    clr_cnt = cc;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask
  initial begin
    #1;
    cyc(1, 0, 0, 0, 16'h0, 0);
    check("rst out_valid", 32'(ov_c), 32'h0);
    check("rst out_data", 32'(od_c), 32'hBEEF);
    check("rst occupancy", 32'(oc_b), 32'h0);
    check("rst bubble_cnt", 32'(bc_a), 32'h0);
    cyc(0, 0, 0, 1, 16'hA5C3, 0);
    check("p1 data", 32'(od_a), 32'hA5C3);
    check("p1 valid", 32'(ov_a), 32'h1);
    cyc(0, 0, 0, 0, 16'h5555, 0);
    check("p1 bubble data", 32'(od_a), 32'h0);
    check("p1 bubble valid", 32'(ov_a), 32'h0);
    cyc(1, 0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 1, 16'(i), 0);
      if (i >= 3) check($sformatf("p2 stream%0d", i), 32'(od_b), 32'(i - 2));
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 16'hFFFF, 0);
      check("p2 stall data", 32'(od_b), 32'h2);
      check("p2 stall occ", 32'(oc_b), 32'h3);
    end
    cyc(0, 0, 0, 0, 16'h0, 0);
    check("p2 drain3", 32'(od_b), 32'h3);
    cyc(0, 0, 0, 0, 16'h0, 0);
    check("p2 drain4", 32'(od_b), 32'h4);
    cyc(1, 0, 0, 0, 16'h0, 0);
    for (int i = 5; i <= 7; i++) cyc(0, 0, 0, 1, 16'(i), 0);
    cyc(0, 1, 1, 1, 16'h9999, 0);
    check("p3 occ mode0", 32'(oc_b), 32'h0);
    check("p3 data mode0", 32'(od_b), 32'h0);
    check("p4 occ keep", 32'(oc_c), 32'h1);
    check("p4 data keep", 32'(od_c), 32'h5);
    cyc(1, 0, 0, 0, 16'h0, 0);
    for (int i = 5; i <= 7; i++) cyc(0, 0, 0, 1, 16'(i), 0);
    cyc(0, 0, 1, 1, 16'h9999, 0);
    check("p4 occ nostall", 32'(oc_c), 32'h0);
    check("p4 data nostall", 32'(od_c), 32'hBEEF);
    cyc(1, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 16'h0, 0);
    check("p5 saturate", 32'(bc_c), 32'h7);
    check("p5 wide cnt", 32'(bc_b), 32'd10);
    cyc(0, 0, 0, 0, 16'h0, 1);
    check("p5 clear", 32'(bc_c), 32'h0);
    cyc(1, 0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 1, 16'h0011, 0);
    cyc(0, 0, 0, 1, 16'h0022, 0);
    check("p6 occ before", 32'(oc_b), 32'h2);
    cyc(1, 1, 0, 1, 16'h0033, 0);
    check("p6 rst occ", 32'(oc_c), 32'h0);
    check("p6 rst data", 32'(od_c), 32'hBEEF);
    cyc(0, 0, 0, 0, 16'hFFFF, 0);
    check("p6 no capture", 32'(od_b), 32'h0);
    for (int i = 0; i < 400; i++) begin
      int p = $urandom_range(99);
      cyc(p < 2, $urandom_range(99) < 25, $urandom_range(99) < 8, $urandom_range(99) < 60,
          16'($urandom), $urandom_range(99) < 5);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
